// File: rtl/spi_counter_pkg.sv
// spi_counter_pkg: shared types and helpers for the counter SPI transmitter.
//   DATA_W / FRAME_W : counter width and SPI frame width
//   spi_tx_state_e   : transmitter FSM states
//   pack_frame()     : builds {p, 1'b0, data}. When SPI_COUNTER_TX_PARITY_EN is
//                      defined, p is odd parity over data; otherwise p = 0.
package spi_counter_pkg;
  localparam int DATA_W  = 14;
  localparam int FRAME_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP
  } spi_tx_state_e;

  function automatic logic [FRAME_W-1:0] pack_frame(input logic [DATA_W-1:0] d);
    logic p;
`ifdef SPI_COUNTER_TX_PARITY_EN
    // Odd parity: {p, d} always holds an odd number of ones.
    p = ~^d;
`else
    p = 1'b0;
`endif
    return {p, 1'b0, d};
  endfunction
endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick: SCLK half-period divider.
//   clk, reset : system clock, async active-high reset
//   clr        : synchronous clear, restarts the count at 0
//   tick       : one-cycle pulse while the count sits at H-1
module spi_half_tick #(
  parameter int H = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = (H > 2) ? $clog2(H) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(H - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/spi_counter_tx.sv
// spi_counter_tx: SPI mode-0 master sending one 16-bit counter frame per start.
//   CLK_DIV : SCLK half-period H in clk cycles (H >= 2)
//   clk, reset : system clock, async active-high reset
//   start   : transmit request, honoured only in IDLE
//   data    : 14-bit counter value, latched when start is accepted
//   sclk, mosi, cs_n : SPI pins, all registered
//   busy    : frame in progress (setup through inter-frame gap)
//   done    : one-cycle pulse on return to IDLE
// Build option: SPI_COUNTER_TX_PARITY_EN puts odd parity in frame bit 15.
module spi_counter_tx
  import spi_counter_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done
);
  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("spi_counter_tx: CLK_DIV must be >= 2");
    end
  endgenerate

  spi_tx_state_e      state, state_n;
  logic [FRAME_W-1:0] sr, sr_n, frame_w;
  logic [4:0]         bit_cnt, bit_cnt_n;
  logic               sclk_q, sclk_n, mosi_q, mosi_n, cs_q, cs_n_n;
  logic               busy_q, busy_n, done_q, done_n;
  logic               tick, clr;

  assign frame_w = pack_frame(data);
  // Divider restarts on every state change so each state lasts exactly H cycles.
  assign clr     = (state_n != state);

  spi_half_tick #(.H(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  // Next-state and next-output logic; outputs are registered from these so
  // every pin changes on the same edge as the state it belongs to.
  always_comb begin
    state_n   = state;
    sr_n      = sr;
    bit_cnt_n = bit_cnt;
    sclk_n    = sclk_q;
    mosi_n    = mosi_q;
    cs_n_n    = cs_q;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = CS_SETUP;
          sr_n      = frame_w;
          bit_cnt_n = 5'd15;
          cs_n_n    = 1'b0;
          sclk_n    = 1'b0;
          mosi_n    = frame_w[FRAME_W-1];
        end
      end
      CS_SETUP: begin
        mosi_n = sr[FRAME_W-1];
        if (tick) begin
          state_n = SHIFT;
          sclk_n  = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            // Falling edge: present the next bit, except after bit 0.
            sclk_n = 1'b0;
            if (bit_cnt != 5'd0) begin
              sr_n   = {sr[FRAME_W-2:0], 1'b0};
              mosi_n = sr[FRAME_W-2];
            end
          end else if (bit_cnt == 5'd0) begin
            state_n = CS_HOLD;
          end else begin
            bit_cnt_n = bit_cnt - 5'd1;
            sclk_n    = 1'b1;
          end
        end
      end
      CS_HOLD: begin
        if (tick) begin
          state_n = GAP;
          cs_n_n  = 1'b1;
          mosi_n  = 1'b0;
        end
      end
      GAP: begin
        if (tick) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cs_n_n  = 1'b1;
        sclk_n  = 1'b0;
        mosi_n  = 1'b0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      bit_cnt <= bit_cnt_n;
      sclk_q  <= sclk_n;
      mosi_q  <= mosi_n;
      cs_q    <= cs_n_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: doc/spi_counter_tx.md
# spi_counter_tx

SPI master transmitter that sits directly downstream of the 14-bit up-counter datapath. On each `start` request it captures the counter value and packs it into a 16-bit frame. It then shifts the frame out MSB-first in SPI mode 0 (CPOL=0, CPHA=0) to the remote display board. Top-level tick logic drives `start` at a fixed refresh rate.

## Interface
- `CLK_DIV`, default 50: SCLK half-period in `clk` cycles, written H below. Legal range is H ≥ 2; elaboration fails otherwise.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  single-cycle transmit request; accepted only in IDLE.
- `data`  input  14  counter value, sampled in the cycle `start` is accepted.
- `sclk`  output  1  SPI clock; idles low.
- `mosi`  output  1  serial data, MSB first.
- `cs_n`  output  1  active-low chip select.
- `busy`  output  1  high while a frame is in progress, including the inter-frame gap.
- `done`  output  1  one-cycle pulse when a frame completes.

## Operation
- **Frame:** `frame[15:0] = {p, 1'b0, data[13:0]}`. The value of `p` is set by Configuration. `data` is latched into a shift register on `start` acceptance, so later changes to `data` do not affect the frame in flight.
- **FSM states:** IDLE → CS_SETUP → SHIFT → CS_HOLD → GAP → IDLE.
- **IDLE:** `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0. If `start`=1, latch the frame and go to CS_SETUP.
- **CS_SETUP** (H cycles): `cs_n`=0, `sclk`=0, `mosi`=`frame[15]`.
- **SHIFT:** 16 bit periods. Each bit period is H cycles with `sclk`=1, then H cycles with `sclk`=0.
  - `mosi` changes only on `sclk` falling edges and presents the next bit.
  - After bit 0's low phase, go to CS_HOLD. There is no shift after the last bit.
  - A 5-bit bit counter runs 15→0.
- **CS_HOLD** (H cycles): `cs_n`=0, `sclk`=0, `mosi` holds bit 0.
- **GAP** (H cycles): `cs_n`=1, `sclk`=0, `mosi`=0. On exit, go to IDLE and pulse `done`.
- **Start while busy:** `start` asserted while `busy`=1 is ignored and not queued.
- **Start during done:** `start` in the cycle `done` is high is accepted, because the FSM is in IDLE.
- **Divider:** a single half-period counter runs 0..H-1 and is cleared on every state change.

## Timing
- **Reset values:** `sclk`=0, `mosi`=0, `cs_n`=1, `busy`=0, `done`=0, FSM=IDLE, shift register=0.
- **Start acceptance:** if `start` is sampled in cycle T, then `cs_n` falls and `busy` rises at T+1.
- **Frame length:** `busy` stays high for exactly 35·H cycles (H setup + 32·H shift + H hold + H gap).
- **First edge:** the first `sclk` rising edge occurs at T+1+H.
- **Clocking:** 16 rising edges per frame. `sclk` period is 2·H; duty cycle is 50%.
- **Done:** `done` is high in the first cycle with `busy`=0 after a frame, i.e. T+1+35·H. It is high for one cycle only.
- **Throughput:** minimum start-to-start spacing is 35·H+1 cycles.
- **Glitch-free outputs:** `sclk`, `mosi` and `cs_n` are registered outputs with no combinational glitches.
- **Reset mid-frame:** outputs return to reset values immediately (asynchronously), and no `done` is issued.
- **Data stability:** a slave sampling on `sclk` rising edges sees `mosi` stable ≥ H cycles before and after each rising edge.

## Configuration
- Macro: `SPI_COUNTER_TX_PARITY_EN`.
- **Defined:** `p` = odd parity over `data[13:0]` (`p = ~^data`). The 15 bits `{p, data}` then always contain an odd number of ones.
- **Undefined:** `p` = 0, and the frame is `{2'b00, data}`.
- Timing and FSM are identical in both builds.

## Structure
- **Package `spi_counter_pkg`:**
  - `DATA_W`=14 and `FRAME_W`=16.
  - State enum `spi_tx_state_e` (IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP).
  - Function `pack_frame(data)`. The parity macro is evaluated inside this function.
- **Sub-module `spi_half_tick`:** parameterised by H. It produces a one-cycle `tick` at count H-1, with a synchronous clear input. The FSM advances only on `tick`.

## Test plan
- **Basic frame:** H=2, without macro, `start` with `data`=14'h1234 → 16 rising edges; slave captures 16'h1234; `busy` high 70 cycles; `done` at T+71.
- **All-ones frame:** H=2, with macro, `data`=14'h3FFF → captured 16'hBFFF; with `data`=14'h1234 → 16'h1234. Without macro, 14'h3FFF → 16'h3FFF.
- **Data change mid-frame:** `data` changes every cycle during the frame → captured value equals the value at `start`.
- **Start while busy:** `start` pulses at T+10 and T+40 (H=2) → exactly one frame, one `done`. `start` coincident with `done` → second frame begins next cycle.
- **Reset mid-frame:** `reset` asserted at bit 7 → `cs_n`=1, `sclk`=0, `mosi`=0 immediately; no `done`; the next `start` produces a full, correct frame.
- **Mode-0 timing:** H=50 → `sclk` period 100 cycles; first rising edge 50 cycles after `cs_n` falls; `mosi` never toggles while `sclk`=1.
